// File: rtl/cd_1001.sv
// cd_1001: Moore detector for serial pattern 1001, overlapping by default.
// Define CD_1001_NONOVERLAP_EN so that bits of a completed match are never reused.
module cd_1001 (
  input  logic clk,
  input  logic signal,
  output logic out,
  input  logic rst
);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;
  state_t state_q, state_d;
  logic out_q, out_d;
`ifdef CD_1001_NONOVERLAP_EN
  localparam state_t s4_on_0 = S0;
`else
  localparam state_t s4_on_0 = S2;
`endif
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = signal ? S1 : S0;
      S1: state_d = signal ? S1 : S2;
      S2: state_d = signal ? S1 : S3;
      S3: state_d = signal ? S4 : S0;
      S4: state_d = signal ? S1 : s4_on_0;
      default: state_d = S0;
    endcase
    // out_q tracks state_q == S4 exactly, so it has no path from signal
    out_d = state_d == S4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
    end
  end
  assign out = out_q;
endmodule

// File: tb/tb_cd_1001.sv
// tb_cd_1001: scoreboard bench for cd_1001; expectations come from a last-four-bits model.
module tb_cd_1001;
`ifdef CD_1001_NONOVERLAP_EN
  localparam bit nonov = 1'b1;
`else
  localparam bit nonov = 1'b0;
`endif
  logic clk = 1'b0;
  logic signal = 1'b0;
  logic rst = 1'b1;
  logic out;
  int checks = 0;
  int failures = 0;
  int exp_pulses = 0;
  int got_pulses = 0;
  bit exp_q[$];
  string tag_q[$];
  logic [3:0] hist = 4'b0;
  int cnt = 0;

  cd_1001 dut (.clk(clk), .signal(signal), .out(out), .rst(rst));

  always #5 clk = ~clk;

  task automatic step(input bit r, input bit b, input string tag);
    bit e;
    @(negedge clk);
    rst = r;
    signal = b;
    if (r) begin
      cnt = 0;
      e = 1'b0;
    end else begin
      hist = {hist[2:0], b};
      cnt = (cnt < 4) ? cnt + 1 : 4;
      e = (cnt == 4) && (hist == 4'b1001);
      if (e && nonov) cnt = 0;
    end
    if (e) exp_pulses++;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic run(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i], tag);
  endtask

  always @(posedge clk) begin
    bit e;
    string t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (out) got_pulses++;
      if (out !== e) begin
        failures++;
        $display("FAIL %s t=%0t: out=%b expected=%b", t, $time, out, e);
      end
    end
  end

  initial begin
    step(1'b1, 1'b1, "reset");
    step(1'b1, 1'b1, "reset");
    run(32'b1001, 4, "basic");
    run(32'b0, 1, "basic_fall");
    step(1'b1, 1'b0, "reset");
    run(32'b11001001, 8, "overlap");
    run(32'b00, 2, "flush");
    run(32'b1010001, 7, "near_miss_a");
    run(32'b10001, 5, "near_miss_b");
    run(32'b00, 2, "flush");
    run(32'b1111001, 7, "ones_run");
    run(32'b1000000000, 10, "zeros_run");
    run(32'b100, 3, "to_s3");
    step(1'b1, 1'b1, "reset_in_s3");
    step(1'b0, 1'b1, "after_reset_s3");
    run(32'b1001001001, 10, "chain");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, ($urandom_range(0, 2) != 0) ^ (i[6]), "random");
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    checks++;
    if (got_pulses != exp_pulses) begin
      failures++;
      $display("FAIL pulse_count: got=%0d expected=%0d", got_pulses, exp_pulses);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
